dmem_stall_ctrl: RTL and testbench
==================================

DMEM_STALL_CTRL -- requirements
Module: dmem_stall_ctrl

Interface
REQ-001 Parameter DATA_W, default 32: data word width in bits; must be a multiple of 8.
REQ-002 Parameter ADDR_W, default 32: byte address width.
REQ-003 Parameter DEPTH, default 256: number of words of storage.
REQ-004 Parameter LATENCY, default 2: wait cycles per access; legal range 0..15.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req  input  1  core access request.
REQ-008 we  input  1  write (1) or read (0); sampled with req.
REQ-009 addr  input  ADDR_W  byte address; word index = addr[ADDR_W-1:2].
REQ-010 wdata  input  DATA_W  write data.
REQ-011 be  input  DATA_W/8  byte enables for writes; bit i selects wdata byte i.
REQ-012 rdata  output  DATA_W  read data; valid only while ready=1.
REQ-013 ready  output  1  one-cycle completion pulse.
REQ-014 stall  output  1  freezes the core pipeline while an access is pending.
REQ-015 err  output  1  out-of-range access flag; valid only while ready=1.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, BUSY and RESP.
REQ-017 IDLE with req=1 at an edge: latch we/addr/wdata/be; load the wait counter with LATENCY; go to BUSY.
REQ-018 IDLE with req=0: remain in IDLE.
REQ-019 BUSY with counter>0 at an edge: decrement the counter.
REQ-020 BUSY with counter=0 at an edge, in-range access: perform the access, register rdata and go to RESP.
REQ-021 Access performed in BUSY: write updates only bytes with be=1; read loads the full stored word.
REQ-022 RESP: drive ready=1 for exactly one cycle; the next edge returns to IDLE unconditionally.
REQ-023 ready SHALL rise exactly LATENCY+2 edges after the accept edge.
REQ-024 Back-to-back requests SHALL NOT be accepted in RESP; they are accepted at the first IDLE edge after RESP.
REQ-025 Inputs SHALL be ignored in BUSY and RESP; only the values latched at accept are used.
REQ-026 stall = (state==BUSY) | (state==IDLE & req), combinational, independent of we.
REQ-027 stall SHALL be 0 in RESP, so the core advances in the cycle ready=1.
REQ-028 Word index >= DEPTH: no write occurs, rdata=0, err=1 in RESP; timing is identical to a normal access.
REQ-029 err SHALL be 0 outside RESP.
REQ-030 Write with be=0: no storage change; ready and timing as normal.
REQ-031 addr[1:0] SHALL be ignored; unaligned accesses map to the containing word.
REQ-032 Read data SHALL reflect all writes that completed earlier.

Reset
REQ-033 Reset SHALL force the following, at any state and dominating req: state=IDLE, counter=0, rdata=0, ready=0, err=0, latched request cleared.
REQ-034 After reset, stall SHALL follow REQ-026 combinationally from IDLE and req.
REQ-035 Reset asserted in BUSY SHALL abort the access: no write is performed and no ready pulse follows.
REQ-036 Storage contents SHALL NOT be altered by reset.
REQ-037 First request accepted SHALL be on the first edge with reset=0 and req=1.

Structure
REQ-038 The shared package dmem_pkg SHALL hold the state enumeration (IDLE, BUSY, RESP) and the parameter defaults.
REQ-039 dmem_pkg SHALL also hold the constant DMEM_CNT_W=4.
REQ-040 Storage SHALL be one sub-module dmem_array: DEPTH x DATA_W, synchronous byte-enable write, registered read.
REQ-041 dmem_stall_ctrl SHALL contain only the FSM, wait counter, request latch and range check.

Verification
REQ-042 LATENCY=2: write addr=0x10, wdata=0xDEADBEEF, be=0xF; read addr=0x10 -> ready 4 edges after accept, rdata=0xDEADBEEF, err=0.
REQ-043 Word 4 holds 0xDEADBEEF; write wdata=0x000000AA, be=0x1; read back -> rdata=0xDEADBEAA.
REQ-044 LATENCY=0: read request -> stall=1 for 2 cycles, ready 2 edges after accept, then IDLE.
REQ-045 DEPTH=256: write addr=0x400 -> err=1 with ready and no write; read addr=0x0 -> prior value unchanged.
REQ-046 Reset in BUSY during a write of 0x12345678 to 0x20 -> no ready pulse; read of 0x20 returns the old value.
REQ-047 req held high continuously -> one ready per LATENCY+3 cycles; stall=0 in each RESP cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// Purpose : shared FSM state encoding and parameter defaults for the data-memory stall controller.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package dmem_pkg;

  localparam int DMEM_DATA_W  = 32;
  localparam int DMEM_ADDR_W  = 32;
  localparam int DMEM_DEPTH   = 256;
  localparam int DMEM_LATENCY = 2;
  localparam int DMEM_CNT_W   = 4;   // wide enough for LATENCY 0..15

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_stall_ctrl_if.sv
// Purpose : core <-> data-memory request/response bundle.
// Latency : n/a (wires only).
// Backpr. : stall from the slave holds the core; ready is a one-cycle completion pulse.
// Ports   : master (core) drives req/we/addr/wdata/be; slave (memory) drives rdata/ready/stall/err.
interface dmem_stall_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] be;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              stall;
  logic              err;

  modport master (
    output req, we, addr, wdata, be,
    input  rdata, ready, stall, err
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output rdata, ready, stall, err
  );
endinterface

// File: rtl/dmem_array.sv
// Purpose : DEPTH x DATA_W word storage with byte-enable write and registered read.
// Latency : write and read both take effect on the edge the enable is sampled; read data held until next load/clear.
// Backpr. : none; enables are issued only by the controller.
// Ports   : clk; i_wr_en/i_be/i_wdat write port; i_rd_en/i_rd_clr read register control; i_idx word index; o_rdat.
module dmem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                i_wr_en,
  input  logic                i_rd_en,
  input  logic                i_rd_clr,
  input  logic [IDX_W-1:0]    i_idx,
  input  logic [DATA_W-1:0]   i_wdat,
  input  logic [DATA_W/8-1:0] i_be,
  output logic [DATA_W-1:0]   o_rdat
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdat;

  // Storage has no reset: contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (i_be[b]) r_mem[i_idx][b*8 +: 8] <= i_wdat[b*8 +: 8];
      end
    end
  end

  // Clear wins so a reset or an out-of-range/write access presents zero read data.
  always_ff @(posedge clk) begin
    if (i_rd_clr)     r_rdat <= '0;
    else if (i_rd_en) r_rdat <= r_mem[i_idx];
  end

  assign o_rdat = r_rdat;

endmodule

// File: rtl/dmem_stall_ctrl.sv
// Purpose : data-memory access controller: accepts one request, waits LATENCY cycles, performs it, pulses ready.
// Latency : ready seen by the core LATENCY+2 edges after the accept edge; a new request is accepted no earlier than RESP+1.
// Backpr. : stall is high while a request waits in IDLE or is pending in BUSY; low in RESP so the core advances.
// Ports   : clk, reset (sync, active-high); bus = slave side of dmem_stall_ctrl_if.
module dmem_stall_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W  = DMEM_DATA_W,
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int DEPTH   = DMEM_DEPTH,
  parameter int LATENCY = DMEM_LATENCY
) (
  input  logic               clk,
  input  logic               reset,
  dmem_stall_ctrl_if.slave   bus
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int AIDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

  dmem_state_e               r_state;
  logic [DMEM_CNT_W-1:0]     r_cnt;
  logic                      r_we;
  logic [IDX_W-1:0]          r_widx;
  logic [DATA_W-1:0]         r_wdata;
  logic [DATA_W/8-1:0]       r_be;
  logic                      r_ready;
  logic                      r_err;

  logic w_in_range;
  logic w_access;
  logic w_wr_en;
  logic w_rd_en;
  logic w_rd_clr;
  logic w_unused_addr;

  // Byte offset within the word is never used; unaligned addresses hit the containing word.
  assign w_unused_addr = &{1'b0, bus.addr[1:0]};

  assign w_in_range = (r_widx < DEPTH_IDX);
  assign w_access   = (r_state == BUSY) && (r_cnt == '0);
  // A reset on the access edge aborts the write.
  assign w_wr_en    = w_access & r_we & w_in_range & ~reset;
  assign w_rd_en    = w_access & ~r_we & w_in_range;
  assign w_rd_clr   = reset | (w_access & ~w_rd_en);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_widx  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req) begin
            r_we    <= bus.we;
            r_widx  <= bus.addr[ADDR_W-1:2];
            r_wdata <= bus.wdata;
            r_be    <= bus.be;
            r_cnt   <= DMEM_CNT_W'(LATENCY);
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state <= RESP;
            r_ready <= 1'b1;
            r_err   <= ~w_in_range;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk      (clk),
    .i_wr_en  (w_wr_en),
    .i_rd_en  (w_rd_en),
    .i_rd_clr (w_rd_clr),
    .i_idx    (r_widx[AIDX_W-1:0]),
    .i_wdat   (r_wdata),
    .i_be     (r_be),
    .o_rdat   (bus.rdata)
  );

  assign bus.ready = r_ready;
  assign bus.err   = r_err;
  assign bus.stall = (r_state == BUSY) | ((r_state == IDLE) & bus.req);

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
module tb_dmem_stall_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_stall_ctrl_if #(.DATA_W(32), .ADDR_W(32)) b2 ();
  dmem_stall_ctrl_if #(.DATA_W(32), .ADDR_W(32)) b0 ();

  dmem_stall_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset), .bus(b2)
  );

  dmem_stall_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(b0)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One access on the LATENCY=2 instance, started at a negedge while IDLE.
  // After the accept edge the request inputs are scrambled; the DUT must use the latched copy.
  // lat = number of edges after accept at which the core samples ready=1 (-1 if never).
  task automatic acc2(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                      output logic [31:0] rd, output logic er, output int lat,
                      output logic rdy_after, output logic err_after);
    b2.req = 1'b1; b2.we = w; b2.addr = a; b2.wdata = d; b2.be = b;
    @(posedge clk); #1;
    b2.req = 1'b0; b2.we = ~w; b2.addr = a ^ 32'h0000_0FFC; b2.wdata = ~d; b2.be = ~b;
    lat = -1; rd = '0; er = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (b2.ready === 1'b1) begin
        rd = b2.rdata; er = b2.err; lat = k;
        break;
      end
    end
    @(negedge clk);
    rdy_after = b2.ready;
    err_after = b2.err;
    b2.we = 1'b0; b2.addr = '0; b2.wdata = '0; b2.be = '0;
  endtask

  task automatic test_reset();
    int lat;
    b2.req = 1'b0; b2.we = 1'b0; b2.addr = '0; b2.wdata = '0; b2.be = '0;
    b0.req = 1'b0; b0.we = 1'b0; b0.addr = '0; b0.wdata = '0; b0.be = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (b2.ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", b2.ready); end
    checks++; if (b2.err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", b2.err); end
    checks++; if (b2.stall !== 1'b0) begin errors++; $display("FAIL rst_stall_idle: got %b expected 0", b2.stall); end
    checks++; if (b2.rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h expected 00000000", b2.rdata); end
    checks++; if (b0.ready !== 1'b0) begin errors++; $display("FAIL rst_ready0: got %b expected 0", b0.ready); end
    // Request raised under reset: stall follows IDLE & req, but nothing is accepted.
    b2.req = 1'b1; b2.we = 1'b1; b2.addr = 32'h30; b2.wdata = 32'h0BAD_CAFE; b2.be = 4'hF;
    #1;
    checks++; if (b2.stall !== 1'b1) begin errors++; $display("FAIL rst_stall_req: got %b expected 1", b2.stall); end
    repeat (2) @(negedge clk);
    checks++; if (b2.stall !== 1'b1 || b2.ready !== 1'b0) begin
      errors++; $display("FAIL rst_hold: stall=%b ready=%b expected stall=1 ready=0", b2.stall, b2.ready); end
    // Release with req high: first accept on the next edge, ready 4 edges later.
    reset = 1'b0;
    @(posedge clk); #1;
    b2.req = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (b2.ready === 1'b1) begin lat = k; break; end
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL first_accept_latency: got %0d expected 4", lat); end
    @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er, ra, ea; int lat;
    acc2(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, er, lat, ra, ea);
    checks++; if (lat !== 4) begin errors++; $display("FAIL wr_latency: got %0d expected 4", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_err: got %b expected 0", er); end
    checks++; if (ra !== 1'b0) begin errors++; $display("FAIL wr_ready_one_cycle: got %b expected 0", ra); end
    acc2(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, ra, ea);
    checks++; if (lat !== 4) begin errors++; $display("FAIL rd_latency: got %0d expected 4", lat); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_err: got %b expected 0", er); end
    // Word written during the reset test.
    acc2(1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat, ra, ea);
    checks++; if (rd !== 32'h0BAD_CAFE) begin errors++; $display("FAIL rd_first_write: got %h expected 0badcafe", rd); end
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd; logic er, ra, ea; int lat;
    acc2(1'b1, 32'h10, 32'h0000_00AA, 4'h1, rd, er, lat, ra, ea);
    acc2(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, ra, ea);
    checks++; if (rd !== 32'hDEAD_BEAA) begin errors++; $display("FAIL be_low_byte: got %h expected deadbeaa", rd); end
    // Unaligned read maps to the containing word.
    acc2(1'b0, 32'h13, 32'h0, 4'h0, rd, er, lat, ra, ea);
    checks++; if (rd !== 32'hDEAD_BEAA) begin errors++; $display("FAIL unaligned_read: got %h expected deadbeaa", rd); end
    // be=0 write: normal timing, no storage change.
    acc2(1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, rd, er, lat, ra, ea);
    checks++; if (lat !== 4) begin errors++; $display("FAIL be0_latency: got %0d expected 4", lat); end
    acc2(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, ra, ea);
    checks++; if (rd !== 32'hDEAD_BEAA) begin errors++; $display("FAIL be0_no_change: got %h expected deadbeaa", rd); end
    // Upper two bytes only, via an unaligned address.
    acc2(1'b1, 32'h12, 32'h1234_0000, 4'hC, rd, er, lat, ra, ea);
    acc2(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, ra, ea);
    checks++; if (rd !== 32'h1234_BEAA) begin errors++; $display("FAIL be_high_half: got %h expected 1234beaa", rd); end
    acc2(1'b1, 32'h10, 32'hDEAD_0000, 4'hC, rd, er, lat, ra, ea);
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic er, ra, ea; int lat;
    acc2(1'b1, 32'h0, 32'h1122_3344, 4'hF, rd, er, lat, ra, ea);
    acc2(1'b1, 32'h400, 32'h5566_7788, 4'hF, rd, er, lat, ra, ea);
    checks++; if (lat !== 4) begin errors++; $display("FAIL oob_wr_latency: got %0d expected 4", lat); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL oob_wr_err: got %b expected 1", er); end
    checks++; if (ea !== 1'b0) begin errors++; $display("FAIL oob_err_after_resp: got %b expected 0", ea); end
    acc2(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat, ra, ea);
    checks++; if (rd !== 32'h1122_3344) begin errors++; $display("FAIL oob_no_alias_write: got %h expected 11223344", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL inrange_err: got %b expected 0", er); end
    acc2(1'b0, 32'h7FC, 32'h0, 4'h0, rd, er, lat, ra, ea);
    checks++; if (rd !== 32'h0 || er !== 1'b1) begin
      errors++; $display("FAIL oob_read: rdata=%h err=%b expected rdata=00000000 err=1", rd, er); end
  endtask

  task automatic test_reset_in_busy();
    logic [31:0] rd; logic er, ra, ea; int lat; int nrdy;
    acc2(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, rd, er, lat, ra, ea);
    b2.req = 1'b1; b2.we = 1'b1; b2.addr = 32'h20; b2.wdata = 32'h1234_5678; b2.be = 4'hF;
    @(posedge clk); #1;
    b2.req = 1'b0;
    // Third negedge after accept: BUSY with counter at 0, so the next edge would write.
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (b2.stall !== 1'b0 || b2.ready !== 1'b0) begin
      errors++; $display("FAIL rst_busy_idle: stall=%b ready=%b expected 0 0", b2.stall, b2.ready); end
    nrdy = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (b2.ready === 1'b1) nrdy++;
    end
    checks++; if (nrdy !== 0) begin errors++; $display("FAIL rst_busy_no_ready: got %0d pulses expected 0", nrdy); end
    acc2(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, ra, ea);
    checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL rst_busy_no_write: got %h expected cafef00d", rd); end
    acc2(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, ra, ea);
    checks++; if (rd !== 32'hDEAD_BEAA) begin errors++; $display("FAIL rst_keeps_storage: got %h expected deadbeaa", rd); end
  endtask

  task automatic test_latency0();
    for (int op = 0; op < 2; op++) begin
      b0.req = 1'b1; b0.we = (op == 0); b0.addr = 32'h8; b0.wdata = 32'hA5A5_0F0F; b0.be = 4'hF;
      #1;
      checks++; if (b0.stall !== 1'b1) begin errors++; $display("FAIL l0_stall_req op%0d: got %b expected 1", op, b0.stall); end
      @(posedge clk); #1;
      b0.req = 1'b0; b0.wdata = 32'h0;
      @(negedge clk);
      checks++; if (b0.stall !== 1'b1 || b0.ready !== 1'b0) begin
        errors++; $display("FAIL l0_busy op%0d: stall=%b ready=%b expected 1 0", op, b0.stall, b0.ready); end
      @(negedge clk);
      checks++; if (b0.ready !== 1'b1 || b0.stall !== 1'b0 || b0.err !== 1'b0) begin
        errors++; $display("FAIL l0_resp op%0d: ready=%b stall=%b err=%b expected 1 0 0", op, b0.ready, b0.stall, b0.err); end
      if (op == 1) begin
        checks++; if (b0.rdata !== 32'hA5A5_0F0F) begin errors++; $display("FAIL l0_rdata: got %h expected a5a50f0f", b0.rdata); end
      end
      @(negedge clk);
      checks++; if (b0.ready !== 1'b0 || b0.stall !== 1'b0) begin
        errors++; $display("FAIL l0_idle op%0d: ready=%b stall=%b expected 0 0", op, b0.ready, b0.stall); end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_r;
    b2.req = 1'b1; b2.we = 1'b0; b2.addr = 32'h10; b2.wdata = '0; b2.be = '0;
    // Cycle 0 waits in IDLE; BUSY for 1..3; RESP at 4; IDLE at 5 re-accepts: period LATENCY+3 = 5.
    for (int n = 0; n < 15; n++) begin
      #1;
      exp_r = ((n % 5) == 4);
      checks++; if (b2.ready !== exp_r) begin errors++; $display("FAIL b2b_ready c%0d: got %b expected %b", n, b2.ready, exp_r); end
      checks++; if (b2.stall !== ~exp_r) begin errors++; $display("FAIL b2b_stall c%0d: got %b expected %b", n, b2.stall, ~exp_r); end
      if (exp_r) begin
        checks++; if (b2.rdata !== 32'hDEAD_BEAA) begin errors++; $display("FAIL b2b_rdata c%0d: got %h expected deadbeaa", n, b2.rdata); end
      end
      @(negedge clk);
    end
    b2.req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_out_of_range();
    test_reset_in_busy();
    test_latency0();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
